// File: rtl/data_memory_responder.sv
// Data-memory responder for the single-cycle core.
// Captures a LOAD/STORE request from Control, holds the core with Stall for LATENCY wait
// cycles, performs the access, then pulses Done for one cycle with the registered load result.
// Optional feature: define DMEM_FAULT_EN to flag misaligned or illegal accesses on MemFault.
// Without it, MemFault is tied low and misaligned or illegal accesses are coerced to legal ones.
module data_memory_responder #(
  parameter int unsigned DEPTH_WORDS = 256,  // power of two, >= 4
  parameter int unsigned LATENCY     = 2     // 1..15
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [2:0]  funct3,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Done,
  output logic        MemFault
);

  localparam int unsigned IdxW = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW = 4;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  // Captured request
  logic            is_store_q;
  logic [2:0]      funct3_q;
  logic [IdxW-1:0] idx_q;
  logic [1:0]      lane_q;
  logic [31:0]     wdata_q;

  logic [31:0] mem_q [DEPTH_WORDS];
  logic [31:0] rdata_q;

  logic        req;
  logic        accept;
  logic        commit;
  logic        is_byte;
  logic        is_half;
  logic [1:0]  lane_eff;
  logic        fault;
  logic [31:0] rd_word;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        sign_ext;
  logic [31:0] load_val;
  logic [3:0]  be;
  logic [31:0] wd;

  // Upper address bits only select aliases of the same word.
  logic unused_addr;
  assign unused_addr = ^Address;

  assign req    = MemRead | MemWrite;
  assign accept = (state_q == StIdle) && req;
  // The access happens on the WAIT->RESP edge; a coincident reset abandons it.
  assign commit = (state_q == StWait) && (cnt_q == '0) && !reset;

  // State register and wait counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic: IDLE -> WAIT -> RESP -> IDLE
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (req) begin
          state_d = StWait;
          cnt_d   = CntLoad;
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs decoded from state; Stall also covers the request cycle itself
  always_comb begin
    Stall    = (state_q == StWait) || ((state_q == StIdle) && req);
    Done     = (state_q == StResp) && !reset;
    MemFault = (state_q == StResp) && !reset && fault;
  end

  // Request capture; both MemRead and MemWrite high is a store
  always_ff @(posedge clock) begin
    if (accept) begin
      is_store_q <= MemWrite;
      funct3_q   <= funct3;
      idx_q      <= Address[IdxW+1:2];
      lane_q     <= Address[1:0];
      wdata_q    <= WriteData;
    end
  end

  // Access size and effective lane; halves and words are forced onto their natural alignment
  always_comb begin
    is_byte = is_store_q ? (funct3_q == 3'b000) : (funct3_q[1:0] == 2'b00);
    is_half = is_store_q ? (funct3_q == 3'b001) : (funct3_q[1:0] == 2'b01);
    if (is_byte) begin
      lane_eff = lane_q;
    end else if (is_half) begin
      lane_eff = {lane_q[1], 1'b0};
    end else begin
      lane_eff = 2'b00;
    end
  end

`ifdef DMEM_FAULT_EN
  // Fault detection: misaligned halves/words and unused funct3 encodings
  always_comb begin
    fault = 1'b0;
    if (is_store_q) begin
      if (funct3_q > 3'b010) begin
        fault = 1'b1;
      end else if (is_half) begin
        fault = lane_q[0];
      end else if (!is_byte) begin
        fault = (lane_q != 2'b00);
      end
    end else begin
      unique case (funct3_q)
        3'b000, 3'b100: fault = 1'b0;
        3'b001, 3'b101: fault = lane_q[0];
        3'b010:         fault = (lane_q != 2'b00);
        default:        fault = 1'b1;
      endcase
    end
  end
`else
  assign fault = 1'b0;
`endif

  // Load path: lane extraction with sign or zero extension
  always_comb begin
    rd_word = mem_q[idx_q];
    unique case (lane_eff)
      2'b00: byte_sel = rd_word[7:0];
      2'b01: byte_sel = rd_word[15:8];
      2'b10: byte_sel = rd_word[23:16];
      2'b11: byte_sel = rd_word[31:24];
      default: byte_sel = rd_word[7:0];
    endcase
    half_sel = lane_eff[1] ? rd_word[31:16] : rd_word[15:0];
    // funct3[2] marks the unsigned load variants
    sign_ext = !funct3_q[2];
    if (is_byte) begin
      load_val = {{24{sign_ext & byte_sel[7]}}, byte_sel};
    end else if (is_half) begin
      load_val = {{16{sign_ext & half_sel[15]}}, half_sel};
    end else begin
      load_val = rd_word;
    end
  end

  // Store path: byte enables and store data replicated onto every lane
  always_comb begin
    be = 4'b1111;
    wd = wdata_q;
    if (is_byte) begin
      be = 4'b0001 << lane_eff;
      wd = {4{wdata_q[7:0]}};
    end else if (is_half) begin
      be = lane_eff[1] ? 4'b1100 : 4'b0011;
      wd = {2{wdata_q[15:0]}};
    end
  end

  // Storage: byte-lane writes at commit; contents survive reset
  always_ff @(posedge clock) begin
    if (commit && is_store_q && !fault) begin
      if (be[0]) mem_q[idx_q][7:0]   <= wd[7:0];
      if (be[1]) mem_q[idx_q][15:8]  <= wd[15:8];
      if (be[2]) mem_q[idx_q][23:16] <= wd[23:16];
      if (be[3]) mem_q[idx_q][31:24] <= wd[31:24];
    end
  end

  // Registered load result; held across stores and idle cycles, cleared on a fault
  always_ff @(posedge clock) begin
    if (reset) begin
      rdata_q <= '0;
    end else if (commit) begin
      if (fault) begin
        rdata_q <= '0;
      end else if (!is_store_q) begin
        rdata_q <= load_val;
      end
    end
  end

  assign ReadData = rdata_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Self-checking bench for data_memory_responder (DEPTH_WORDS=256, LATENCY=2).
// A byte-addressed reference memory predicts every cycle's Stall/Done/MemFault/ReadData;
// directed accesses additionally check hand-computed results and timing.
module tb_data_memory_responder;

  localparam int unsigned Depth = 256;
  localparam int unsigned Lat   = 2;
  localparam int          Bytes = 4 * Depth;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        MemRead = 1'b0;
  logic        MemWrite = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] Address = '0;
  logic [31:0] WriteData = '0;
  logic [31:0] ReadData;
  logic        Stall;
  logic        Done;
  logic        MemFault;

  data_memory_responder #(
    .DEPTH_WORDS(Depth),
    .LATENCY    (Lat)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .funct3   (funct3),
    .Address  (Address),
    .WriteData(WriteData),
    .ReadData (ReadData),
    .Stall    (Stall),
    .Done     (Done),
    .MemFault (MemFault)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference memory, one entry per byte with a known flag
  logic [7:0] mb [Bytes];
  bit         kn [Bytes];

  task automatic model_exec(input bit wr, input logic [2:0] f3, input logic [31:0] a,
                            input logic [31:0] wdat, output logic [31:0] rd,
                            output bit rd_known, output bit flt);
    int size;
    int base;
    bit uns;
    logic [31:0] v;
    if (wr) size = (f3 == 3'd0) ? 1 : (f3 == 3'd1) ? 2 : 4;
    else    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    uns = !wr && (f3 == 3'b100 || f3 == 3'b101);
    flt = 1'b0;
`ifdef DMEM_FAULT_EN
    if (wr && f3 > 3'd2) flt = 1'b1;
    if (!wr && (f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7)) flt = 1'b1;
    if ((int'(a[1:0]) % size) != 0) flt = 1'b1;
`endif
    base = int'(a % 32'(Bytes));
    base = base - (base % size);
    rd = '0;
    rd_known = 1'b1;
    if (flt) begin
      rd = '0;
    end else if (wr) begin
      for (int k = 0; k < size; k++) begin
        mb[base + k] = wdat[8*k +: 8];
        kn[base + k] = 1'b1;
      end
    end else begin
      v = '0;
      for (int k = 0; k < size; k++) begin
        v = v | (32'(mb[base + k]) << (8 * k));
        if (!kn[base + k]) rd_known = 1'b0;
      end
      if (!uns && size < 4 && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8 * size));
      rd = v;
    end
  endtask

  // Per-cycle model: a request accepted in cycle T completes in cycle T+Lat+1
  bit          pending   = 1'b0;
  bit          rst_seen  = 1'b0;
  int          cyc       = 0;
  int          resp_c    = 0;
  bit          p_wr;
  logic [2:0]  p_f3;
  logic [31:0] p_a;
  logic [31:0] p_wd;
  logic [31:0] exp_rd    = '0;
  bit          exp_rd_kn = 1'b0;

  always @(negedge clock) begin : cmp
    logic [31:0] r;
    bit rk;
    bit f;
    bit at_resp;
    bit exp_done;
    bit exp_flt;
    at_resp  = pending && (cyc == resp_c);
    exp_done = 1'b0;
    exp_flt  = 1'b0;
    if (at_resp) begin
      model_exec(p_wr, p_f3, p_a, p_wd, r, rk, f);
      exp_done = !reset;
      exp_flt  = f && !reset;
      if (!p_wr || f) begin
        exp_rd    = r;
        exp_rd_kn = rk;
      end
    end
    if (rst_seen) begin
      check("cyc_Stall", 32'(Stall), pending ? 32'(cyc < resp_c) : 32'(MemRead | MemWrite));
      check("cyc_Done", 32'(Done), 32'(exp_done));
      check("cyc_MemFault", 32'(MemFault), 32'(exp_flt));
      if (exp_rd_kn) check("cyc_ReadData", ReadData, exp_rd);
    end
    if (reset) begin
      pending   = 1'b0;
      exp_rd    = '0;
      exp_rd_kn = 1'b1;
      rst_seen  = 1'b1;
    end else if (at_resp) begin
      pending = 1'b0;
    end else if (!pending && (MemRead | MemWrite)) begin
      pending = 1'b1;
      resp_c  = cyc + Lat + 1;
      p_wr    = MemWrite;
      p_f3    = funct3;
      p_a     = Address;
      p_wd    = WriteData;
    end
    cyc++;
  end

  // One complete access with timing and result checks against literal expectations
  task automatic op(input string nm, input bit rq, input bit wq, input logic [2:0] f3,
                    input logic [31:0] a, input logic [31:0] wdat, input bit ck_rd,
                    input logic [31:0] exp_r, input bit exp_f);
    int stalls;
    int dc;
    logic [31:0] rd;
    logic flt;
    @(posedge clock);
    #1;
    MemRead = rq; MemWrite = wq; funct3 = f3; Address = a; WriteData = wdat;
    stalls = 0; dc = 0; rd = '0; flt = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clock);
      if (Stall) stalls++;
      if (Done) begin
        dc = i; rd = ReadData; flt = MemFault;
        break;
      end
      @(posedge clock);
      #1;
      MemRead = 1'b0; MemWrite = 1'b0;
    end
    MemRead = 1'b0; MemWrite = 1'b0;
    if (dc == 0) begin
      check({nm, "_timeout"}, 32'(dc), 32'(Lat + 2));
    end else begin
      check({nm, "_done_cycle"}, 32'(dc), 32'd4);
      check({nm, "_stall_cycles"}, 32'(stalls), 32'd3);
      check({nm, "_fault"}, 32'(flt), 32'(exp_f));
      if (ck_rd) check({nm, "_rd"}, rd, exp_r);
    end
  endtask

  localparam bit FaultEn =
`ifdef DMEM_FAULT_EN
    1'b1;
`else
    1'b0;
`endif

  initial begin
    repeat (3) @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("reset_ReadData", ReadData, 32'h0);
    check("reset_Stall", 32'(Stall), 32'd0);
    check("reset_Done", 32'(Done), 32'd0);
    check("reset_MemFault", 32'(MemFault), 32'd0);

    op("sw_deadbeef", 0, 1, 3'b010, 32'h10, 32'hDEAD_BEEF, 1, 32'h0, 0);
    op("lw_deadbeef", 1, 0, 3'b010, 32'h10, 32'h0, 1, 32'hDEAD_BEEF, 0);
    op("sw_11223344", 0, 1, 3'b010, 32'h10, 32'h1122_3344, 1, 32'hDEAD_BEEF, 0);
    op("sb_80", 0, 1, 3'b000, 32'h13, 32'hFFFF_FF80, 1, 32'hDEAD_BEEF, 0);
    op("lw_after_sb", 1, 0, 3'b010, 32'h10, 32'h0, 1, 32'h8022_3344, 0);
    op("lb_13", 1, 0, 3'b000, 32'h13, 32'h0, 1, 32'hFFFF_FF80, 0);
    op("lbu_13", 1, 0, 3'b100, 32'h13, 32'h0, 1, 32'h0000_0080, 0);
    op("lb_11", 1, 0, 3'b000, 32'h11, 32'h0, 1, 32'h0000_0033, 0);
    op("lw_f3_011", 1, 0, 3'b011, 32'h10, 32'h0, 1, FaultEn ? 32'h0 : 32'h8022_3344, FaultEn);

    op("sw_12345678", 0, 1, 3'b010, 32'h20, 32'h1234_5678, 0, 32'h0, 0);
    op("sh_beef", 0, 1, 3'b001, 32'h22, 32'hFFFF_BEEF, 0, 32'h0, 0);
    op("lh_22", 1, 0, 3'b001, 32'h22, 32'h0, 1, 32'hFFFF_BEEF, 0);
    op("lhu_22", 1, 0, 3'b101, 32'h22, 32'h0, 1, 32'h0000_BEEF, 0);
    op("lw_after_sh", 1, 0, 3'b010, 32'h20, 32'h0, 1, 32'hBEEF_5678, 0);
    op("lh_23", 1, 0, 3'b001, 32'h23, 32'h0, 1, FaultEn ? 32'h0 : 32'hFFFF_BEEF, FaultEn);

    // Both request lines high is a store and leaves ReadData alone
    op("rw_both", 1, 1, 3'b010, 32'h30, 32'h0BAD_CAFE, 1, FaultEn ? 32'h0 : 32'hFFFF_BEEF, 0);
    op("lw_30", 1, 0, 3'b010, 32'h30, 32'h0, 1, 32'h0BAD_CAFE, 0);
    op("sw_f3_111", 0, 1, 3'b111, 32'h34, 32'h1357_9BDF, 1, FaultEn ? 32'h0 : 32'h0BAD_CAFE,
       FaultEn);
    if (!FaultEn) op("lw_34", 1, 0, 3'b010, 32'h34, 32'h0, 1, 32'h1357_9BDF, 0);

    op("sw_cafef00d", 0, 1, 3'b010, 32'h4, 32'hCAFE_F00D, 0, 32'h0, 0);
    op("lw_06", 1, 0, 3'b010, 32'h6, 32'h0, 1, FaultEn ? 32'h0 : 32'hCAFE_F00D, FaultEn);

    // Reset in WAIT abandons the store
    op("sw_zero", 0, 1, 3'b010, 32'h0, 32'h0, 0, 32'h0, 0);
    @(posedge clock);
    #1;
    MemWrite = 1'b1; funct3 = 3'b010; Address = 32'h0; WriteData = 32'h55;
    @(posedge clock);
    #1;
    MemWrite = 1'b0; reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    @(negedge clock);
    check("abort_idle_Stall", 32'(Stall), 32'd0);
    check("abort_Done", 32'(Done), 32'd0);
    check("abort_ReadData", ReadData, 32'h0);
    repeat (4) begin
      @(negedge clock);
      check("abort_no_Done", 32'(Done), 32'd0);
    end
    op("lw_after_abort", 1, 0, 3'b010, 32'h0, 32'h0, 1, 32'h0, 0);

    op("sw_wrap", 0, 1, 3'b010, 32'h400, 32'hA5A5_A5A5, 0, 32'h0, 0);
    op("lw_wrap", 1, 0, 3'b010, 32'h0, 32'h0, 1, 32'hA5A5_A5A5, 0);

    repeat (3) @(negedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
